pc_sequencer: RTL and testbench

Multi-cycle fetch/next-PC controller for the CPU31 core. It sequences the program-counter register: it drives the PC register's enable and next-value inputs, runs the instruction-memory fetch handshake, and selects the next PC from branch, jump, jump-register, exception and eret requests. It sits between the PC register, the instruction memory port and the execute stage's completion/redirect signals.

---
 rtl/pc_sequencer_if.sv | 40 ++++
 rtl/pc_sequencer.sv | 145 ++++++++++++++
 tb/tb_pc_sequencer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Bundle of PC-register, instruction-fetch and execute-redirect signals around pc_sequencer.
// The master modport is the sequencer's view; the slave modport is the surrounding core's view.
interface pc_sequencer_if;
  logic [31:0] i_pc_cur;
  logic [31:0] o_pc_next;
  logic        o_pc_ena;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_ack;
  logic        i_exec_valid;
  logic        i_br_taken;
  logic [31:0] i_br_target;
  logic        i_jump;
  logic [31:0] i_jump_target;
  logic        i_jr;
  logic [31:0] i_jr_target;
  logic        i_exc;
  logic        i_eret;
  logic [31:0] i_epc;
  logic        i_stall;
  logic        o_busy;
  logic        o_fetch_err;
  logic        o_addr_err;

  modport master (
    input  i_pc_cur, i_imem_ack, i_exec_valid,
    input  i_br_taken, i_br_target, i_jump, i_jump_target,
    input  i_jr, i_jr_target, i_exc, i_eret, i_epc, i_stall,
    output o_pc_next, o_pc_ena, o_imem_req, o_imem_addr,
    output o_busy, o_fetch_err, o_addr_err
  );

  modport slave (
    output i_pc_cur, i_imem_ack, i_exec_valid,
    output i_br_taken, i_br_target, i_jump, i_jump_target,
    output i_jr, i_jr_target, i_exc, i_eret, i_epc, i_stall,
    input  o_pc_next, o_pc_ena, o_imem_req, o_imem_addr,
    input  o_busy, o_fetch_err, o_addr_err
  );
endinterface

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/next-PC controller: BOOT -> FETCH -> EXEC -> UPDATE -> FETCH ...
// Drives the PC register load, the imem fetch handshake and next-PC selection.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR  = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR    = 32'h0040_0004,
  parameter int unsigned FETCH_TIMEOUT = 15
) (
  input  logic           clk,
  input  logic           rst_n,
  pc_sequencer_if.master bus
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_EXEC   = 2'd2,
    ST_UPDATE = 2'd3
  } state_t;

  localparam logic [3:0] TIMEOUT_LAST = 4'(FETCH_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc_next;
  logic [3:0]  r_wait_cnt;
  logic        r_fetch_err;
  logic        r_addr_err;

  logic        w_timeout;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_sel_target;
  logic        w_sel_is_exc;
  logic        w_misaligned;
  logic        w_pc_ena;
  logic        w_imem_req;
  logic        w_busy;
  logic [31:0] w_imem_addr;

  assign w_pc_plus4 = bus.i_pc_cur + 32'd4;

  // The counter holds the number of ack-less FETCH cycles already spent.
  assign w_timeout = (r_state == ST_FETCH) && !bus.i_imem_ack &&
                     (r_wait_cnt == TIMEOUT_LAST);

  always_comb begin
    w_sel_target = w_pc_plus4;
    w_sel_is_exc = 1'b0;
    if (bus.i_exc) begin
      w_sel_target = EXC_VECTOR;
      w_sel_is_exc = 1'b1;
    end else if (bus.i_eret) begin
      w_sel_target = bus.i_epc;
    end else if (bus.i_jr) begin
      w_sel_target = bus.i_jr_target;
    end else if (bus.i_jump) begin
      w_sel_target = bus.i_jump_target;
    end else if (bus.i_br_taken) begin
      w_sel_target = bus.i_br_target;
    end
    w_misaligned = !w_sel_is_exc && (w_sel_target[1:0] != 2'b00);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pc_ena     = 1'b0;
    w_imem_req   = 1'b0;
    w_busy       = 1'b0;
    w_imem_addr  = 32'd0;
    case (r_state)
      ST_BOOT: begin
        // Held low while reset is asserted so no load happens before release.
        w_pc_ena     = rst_n;
        w_state_next = ST_FETCH;
      end
      ST_FETCH: begin
        w_imem_req  = 1'b1;
        w_busy      = 1'b1;
        w_imem_addr = bus.i_pc_cur;
        if (bus.i_imem_ack) begin
          w_state_next = ST_EXEC;
        end else if (w_timeout) begin
          w_state_next = ST_UPDATE;
        end
      end
      ST_EXEC: begin
        w_busy = 1'b1;
        if (bus.i_exec_valid) begin
          w_state_next = ST_UPDATE;
        end
      end
      ST_UPDATE: begin
        w_pc_ena = !bus.i_stall;
        if (!bus.i_stall) begin
          w_state_next = ST_FETCH;
        end
      end
      default: begin
        w_state_next = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc_next   <= RESET_VECTOR;
      r_wait_cnt  <= 4'd0;
      r_fetch_err <= 1'b0;
      r_addr_err  <= 1'b0;
    end else begin
      r_fetch_err <= w_timeout;
      r_addr_err  <= 1'b0;
      if (r_state == ST_FETCH) begin
        if (!bus.i_imem_ack) begin
          r_wait_cnt <= r_wait_cnt + 4'd1;
        end
      end else begin
        r_wait_cnt <= 4'd0;
      end
      if (w_timeout) begin
        r_pc_next <= EXC_VECTOR;
      end
      if ((r_state == ST_EXEC) && bus.i_exec_valid) begin
        r_pc_next  <= w_misaligned ? EXC_VECTOR : w_sel_target;
        r_addr_err <= w_misaligned;
      end
    end
  end

  assign bus.o_pc_next   = r_pc_next;
  assign bus.o_pc_ena    = w_pc_ena;
  assign bus.o_imem_req  = w_imem_req;
  assign bus.o_imem_addr = w_imem_addr;
  assign bus.o_busy      = w_busy;
  assign bus.o_fetch_err = r_fetch_err;
  assign bus.o_addr_err  = r_addr_err;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios followed by randomized instructions,
// each checked cycle by cycle against a next-PC model computed from the selection rules.
module tb_pc_sequencer;
  localparam logic [31:0] RV = 32'h0040_0000;
  localparam logic [31:0] EV = 32'h0040_0004;
  localparam int          TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR (RV),
    .EXC_VECTOR   (EV),
    .FETCH_TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {addr_err, next_pc}: first requested target in priority order, else pc+4.
  function automatic logic [32:0] model_next(
      input logic [31:0] pc, input logic exc, input logic eret, input logic [31:0] epc,
      input logic jr, input logic [31:0] jrt, input logic jump, input logic [31:0] jt,
      input logic br, input logic [31:0] bt);
    logic [31:0] cand[$];
    logic [31:0] t;
    longint unsigned sum;
    if (exc) return {1'b0, EV};
    if (eret) cand.push_back(epc);
    if (jr)   cand.push_back(jrt);
    if (jump) cand.push_back(jt);
    if (br)   cand.push_back(bt);
    sum = longint'(pc) + 64'd4;
    cand.push_back(32'(sum % 64'h1_0000_0000));
    t = cand[0];
    if ((t % 4) != 0) return {1'b1, EV};
    return {1'b0, t};
  endfunction

  task automatic drive_redirects(input logic e, input logic er, input logic j_r, input logic jp,
      input logic b, input logic [31:0] ep, input logic [31:0] jrt, input logic [31:0] jt,
      input logic [31:0] bt);
    bus.i_exc = e;  bus.i_eret = er; bus.i_jr = j_r; bus.i_jump = jp; bus.i_br_taken = b;
    bus.i_epc = ep; bus.i_jr_target = jrt; bus.i_jump_target = jt; bus.i_br_target = bt;
  endtask

  task automatic drive_junk();
    logic [31:0] r;
    r = $urandom;
    drive_redirects(r[0], r[1], r[2], r[3], r[4], $urandom, $urandom, $urandom, $urandom);
  endtask

  // Entered at posedge+1 of the first FETCH cycle; returns at posedge+1 of the next one.
  task automatic run_instr(input logic [31:0] pc, input int ack_dly, input int ev_dly,
      input int stalls, input logic e, input logic er, input logic j_r, input logic jp,
      input logic b, input logic [31:0] ep, input logic [31:0] jrt, input logic [31:0] jt,
      input logic [31:0] bt);
    logic        timed_out;
    logic [32:0] exp;
    logic        junk;
    timed_out = 1'b0;
    bus.i_pc_cur = pc;
    bus.i_stall  = 1'b0;
    for (int c = 0; c < TO; c++) begin
      bus.i_imem_ack   = (c == ack_dly);
      bus.i_exec_valid = 1'b1;
      drive_junk();
      #1;
      chk("fetch_req",  bus.o_imem_req, 32'd1);
      chk("fetch_busy", bus.o_busy, 32'd1);
      chk("fetch_addr", bus.o_imem_addr, pc);
      chk("fetch_ena",  bus.o_pc_ena, 32'd0);
      @(posedge clk); #1;
      bus.i_imem_ack = 1'b0;
      if (c == ack_dly) break;
      if (c == TO - 1) timed_out = 1'b1;
    end
    if (timed_out) begin
      exp = {1'b0, EV};
    end else begin
      for (int c = 0; c <= ev_dly; c++) begin
        junk = 1'($urandom_range(0, 1));
        bus.i_imem_ack = junk;
        if (c == ev_dly) begin
          bus.i_exec_valid = 1'b1;
          drive_redirects(e, er, j_r, jp, b, ep, jrt, jt, bt);
        end else begin
          bus.i_exec_valid = 1'b0;
          drive_junk();
        end
        #1;
        chk("exec_busy", bus.o_busy, 32'd1);
        chk("exec_req",  bus.o_imem_req, 32'd0);
        chk("exec_addr", bus.o_imem_addr, 32'd0);
        chk("exec_ena",  bus.o_pc_ena, 32'd0);
        @(posedge clk); #1;
      end
      exp = model_next(pc, e, er, ep, j_r, jrt, jp, jt, b, bt);
    end
    for (int c = 0; c <= stalls; c++) begin
      bus.i_exec_valid = 1'b0;
      bus.i_imem_ack   = 1'($urandom_range(0, 1));
      bus.i_stall      = (c < stalls);
      drive_junk();
      #1;
      chk("upd_pc_next",   bus.o_pc_next, exp[31:0]);
      chk("upd_pc_ena",    bus.o_pc_ena, (c < stalls) ? 32'd0 : 32'd1);
      chk("upd_busy",      bus.o_busy, 32'd0);
      chk("upd_fetch_err", bus.o_fetch_err, {31'd0, timed_out && (c == 0)});
      chk("upd_addr_err",  bus.o_addr_err, {31'd0, exp[32] && (c == 0)});
      @(posedge clk); #1;
    end
    bus.i_stall    = 1'b0;
    bus.i_imem_ack = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_ena"},    bus.o_pc_ena, 32'd0);
    chk({tag, "_pc_next"},   bus.o_pc_next, RV);
    chk({tag, "_req"},       bus.o_imem_req, 32'd0);
    chk({tag, "_addr"},      bus.o_imem_addr, 32'd0);
    chk({tag, "_busy"},      bus.o_busy, 32'd0);
    chk({tag, "_fetch_err"}, bus.o_fetch_err, 32'd0);
    chk({tag, "_addr_err"},  bus.o_addr_err, 32'd0);
  endtask

  function automatic logic [31:0] rnd_target();
    logic [31:0] t;
    t = $urandom;
    if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
    return t;
  endfunction

  initial begin
    logic [31:0] pc;
    logic [31:0] fl;
    bus.i_pc_cur = 32'h0040_0000;
    bus.i_imem_ack = 1'b0;
    bus.i_exec_valid = 1'b0;
    bus.i_stall = 1'b0;
    drive_redirects(0, 0, 0, 0, 0, 0, 0, 0, 0);

    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    #1;
    chk("boot_pc_ena",  bus.o_pc_ena, 32'd1);
    chk("boot_pc_next", bus.o_pc_next, RV);
    chk("boot_busy",    bus.o_busy, 32'd0);
    @(posedge clk); #1;

    run_instr(32'h0040_0010, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0040_0020, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 32'h0040_0200, 32'h0040_0100);
    run_instr(32'h0040_0020, 0, 0, 0, 1, 0, 0, 1, 1, 0, 0, 32'h0040_0200, 32'h0040_0100);
    run_instr(32'h0040_0030, 99, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0040_0040, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0102, 0, 0);
    run_instr(32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0040_0050, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(32'h0040_0060, 2, 1, 0, 0, 1, 1, 0, 0, 32'h0000_8000, 32'h0000_9000, 0, 0);
    run_instr(32'h0040_0070, TO - 1, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0404);

    for (int k = 0; k < 40; k++) begin
      pc = $urandom;
      pc[1:0] = 2'b00;
      if ($urandom_range(0, 7) == 0) pc = 32'hFFFF_FFFC;
      fl = $urandom;
      run_instr(pc, $urandom_range(0, 17), $urandom_range(0, 3), $urandom_range(0, 3),
                fl[2:0] == 3'd0, fl[4:3] == 2'd0, fl[6:5] == 2'd0, fl[8:7] == 2'd0,
                fl[10:9] == 2'd0, rnd_target(), rnd_target(), rnd_target(), rnd_target());
    end

    run_instr(32'h0040_0080, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 32'h0040_0A00, 0);
    bus.i_pc_cur = 32'h0040_0A00;
    #1;
    chk("pre_rst_req", bus.o_imem_req, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    #2;
    rst_n = 1'b1;
    #1;
    chk("reboot_pc_ena",  bus.o_pc_ena, 32'd1);
    chk("reboot_pc_next", bus.o_pc_next, RV);
    @(posedge clk); #1;
    run_instr(32'h0040_0000, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
